if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 25 ++
 rtl/if_fetch.sv | 109 ++++++++++
 tb/tb_if_fetch.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: execute redirect, decoder handoff and byte-memory port.
//   master : the fetch unit (drives memory requests and the decoder handoff)
//   slave  : the surrounding pipeline/memory (drives redirect, ready, grant, data)
interface if_fetch_if;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        id_ready;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  modport master (
    input  jump_en, jump_target, id_ready, mem_gnt, mem_din,
    output mem_rd_en, mem_addr, pc_out, inst_out, inst_valid
  );

  modport slave (
    output jump_en, jump_target, id_ready, mem_gnt, mem_din,
    input  mem_rd_en, mem_addr, pc_out, inst_out, inst_valid
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch over a byte-wide memory port. Issues four byte reads
// (PC..PC+3), assembles them little-endian into a 32-bit instruction and holds
// it for the decoder until accepted. A redirect from execute flushes all
// in-flight work and restarts at the word-aligned jump target.
//   clk, rst             : clock, synchronous active-high reset
//   bus.jump_en/target   : redirect request and byte address
//   bus.id_ready         : decoder accepts the held instruction
//   bus.mem_rd_en/addr   : byte-read request (combinational)
//   bus.mem_gnt          : request accepted when rd_en & gnt
//   bus.mem_din          : byte for the request accepted one cycle earlier
//   bus.pc_out/inst_out/inst_valid : registered decoder handoff
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.master bus
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [2:0]  issued_q;
  logic [2:0]  recv_q;
  logic        pending_q;   // a request was accepted last cycle; its byte is on mem_din now
  logic [31:0] pc_out_q;
  logic [31:0] inst_q;
  logic        valid_q;

  logic        rd_en;
  logic [31:0] addr;
  logic        accept;
  logic        capture;
  logic        transfer;

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    addr     = pc_q + {29'd0, issued_q};
    capture  = pending_q && !bus.jump_en;
    transfer = 1'b0;
    unique case (state_q)
      FETCH: begin
        rd_en = (issued_q < 3'd4) && !bus.jump_en;
        if (capture && recv_q == 3'd3) state_d = HOLD;
      end
      HOLD: begin
        transfer = bus.id_ready && !bus.jump_en;
        if (transfer) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (bus.jump_en) state_d = FETCH;
    if (rst) begin
      state_d = FETCH;
      rd_en   = 1'b0;
      addr    = '0;
    end
    accept = rd_en && bus.mem_gnt;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      issued_q  <= '0;
      recv_q    <= '0;
      pending_q <= 1'b0;
      pc_out_q  <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
    end else if (bus.jump_en) begin
      // Dropping pending_q discards the byte of any request already in flight.
      pc_q      <= {bus.jump_target[31:2], 2'b00};
      issued_q  <= '0;
      recv_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= accept;
      if (accept) issued_q <= issued_q + 3'd1;
      if (capture) begin
        inst_q[{recv_q[1:0], 3'b000} +: 8] <= bus.mem_din;
        recv_q <= recv_q + 3'd1;
        if (recv_q == 3'd3) begin
          valid_q  <= 1'b1;
          pc_out_q <= pc_q;
        end
      end
      if (transfer) begin
        valid_q  <= 1'b0;
        pc_q     <= pc_q + 32'd4;
        issued_q <= '0;
        recv_q   <= '0;
      end
    end
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = addr;
  assign bus.pc_out     = pc_out_q;
  assign bus.inst_out   = inst_q;
  assign bus.inst_valid = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized traffic. A
// byte memory responds to accepted requests; an instruction-stream model
// predicts which addresses are requested and which (pc, word) pairs reach the
// decoder.
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ntransfer = 0;
  logic [31:0] exp_pc = RST_PC;
  int unsigned nreq = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: update the stream model from this cycle's inputs/outputs,
  // cross the edge, then return the byte for any request just accepted.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    #1;
    acc = (bus.mem_rd_en === 1'b1) && (bus.mem_gnt === 1'b1);
    a   = bus.mem_addr;
    if (rst) begin
      exp_pc = RST_PC;
      nreq   = 0;
    end else if (bus.jump_en) begin
      chk("no_req_on_jump", {31'd0, bus.mem_rd_en}, 32'd0);
      exp_pc = {bus.jump_target[31:2], 2'b00};
      nreq   = 0;
    end else begin
      if (bus.inst_valid === 1'b1) chk("no_req_in_hold", {31'd0, bus.mem_rd_en}, 32'd0);
      if (acc) begin
        chk("req_addr", a, exp_pc + 32'(nreq));
        chk("req_count", {31'd0, nreq < 4}, 32'd1);
        nreq++;
      end
      if (bus.inst_valid === 1'b1 && bus.id_ready) begin
        chk("xfer_pc", bus.pc_out, exp_pc);
        chk("xfer_inst", bus.inst_out, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        nreq   = 0;
        ntransfer++;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_din = acc ? mem_byte(a) : 8'($urandom);
  endtask

  task automatic wait_valid(input int unsigned max, output int unsigned n);
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, bus.inst_valid}, 32'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pc_out", bus.pc_out, 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [31:0] p, w;

    rst = 1'b1;
    bus.jump_en = 1'b0;
    bus.jump_target = '0;
    bus.id_ready = 1'b1;
    bus.mem_gnt = 1'b1;
    bus.mem_din = '0;
    tick();
    tick();
    #1 chk_reset_outputs();

    // Basic fetch timing from reset.
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      chk("c14_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
      chk("c14_addr", bus.mem_addr, 32'(i));
      tick();
    end
    #1;
    chk("c5_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    chk("c5_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    #1;
    chk("c6_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("c6_pc", bus.pc_out, 32'd0);
    chk("c6_inst", bus.inst_out, 32'h0010_0513);
    tick();
    #1;
    chk("c7_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("c7_addr", bus.mem_addr, 32'd4);
    chk("c7_valid", {31'd0, bus.inst_valid}, 32'd0);

    // Decoder stall: outputs frozen, no requests.
    bus.id_ready = 1'b0;
    wait_valid(12, n);
    chk("lat_nominal", n, 32'd5);
    chk("hold_pc", bus.pc_out, 32'd4);
    chk("hold_inst", bus.inst_out, mem_word(32'd4));
    p = bus.pc_out;
    w = bus.inst_out;
    repeat (10) begin
      #1;
      chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("stall_pc", bus.pc_out, p);
      chk("stall_inst", bus.inst_out, w);
      chk("stall_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
      tick();
    end
    bus.id_ready = 1'b1;
    tick();
    #1;
    chk("post_xfer_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("post_xfer_addr", bus.mem_addr, 32'd8);

    // Grant withheld for 3 cycles at byte 2.
    bus.id_ready = 1'b0;
    tick();
    tick();
    bus.mem_gnt = 1'b0;
    repeat (3) begin
      #1;
      chk("gnt_hold_addr", bus.mem_addr, 32'hA);
      chk("gnt_hold_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
      tick();
    end
    bus.mem_gnt = 1'b1;
    wait_valid(12, n);
    chk("gnt_lat", n, 32'd3);
    chk("gnt_pc", bus.pc_out, 32'd8);
    chk("gnt_inst", bus.inst_out, mem_word(32'd8));
    bus.id_ready = 1'b1;
    tick();

    // Jump mid-fetch at PC 0, byte 1.
    bus.jump_en = 1'b1;
    bus.jump_target = 32'd0;
    tick();
    bus.jump_en = 1'b0;
    bus.id_ready = 1'b0;
    tick();
    bus.jump_en = 1'b1;
    bus.jump_target = 32'h103;
    #1 chk("jump_no_req", {31'd0, bus.mem_rd_en}, 32'd0);
    tick();
    bus.jump_en = 1'b0;
    #1;
    chk("jump_addr", bus.mem_addr, 32'h100);
    chk("jump_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    wait_valid(12, n);
    chk("jump_pc", bus.pc_out, 32'h100);
    chk("jump_inst", bus.inst_out, mem_word(32'h100));

    // Jump coincident with valid & ready flushes the held instruction.
    bus.id_ready = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_target = 32'h40;
    tick();
    bus.jump_en = 1'b0;
    #1;
    chk("flush_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("flush_addr", bus.mem_addr, 32'h40);
    chk("flush_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    bus.id_ready = 1'b0;
    wait_valid(12, n);
    chk("flush_pc", bus.pc_out, 32'h40);
    bus.id_ready = 1'b1;
    tick();

    // Address wrap at the top of memory.
    bus.jump_en = 1'b1;
    bus.jump_target = 32'hFFFF_FFFE;
    tick();
    bus.jump_en = 1'b0;
    bus.id_ready = 1'b0;
    wait_valid(12, n);
    chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_inst", bus.inst_out, mem_word(32'hFFFF_FFFC));
    bus.id_ready = 1'b1;
    tick();
    #1;
    chk("wrap_next_addr", bus.mem_addr, 32'd0);
    chk("wrap_next_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);

    // Reset during byte 2 of a fetch at 0x8.
    bus.jump_en = 1'b1;
    bus.jump_target = 32'h8;
    tick();
    bus.jump_en = 1'b0;
    tick();
    tick();
    #1 chk("pre_rst_addr", bus.mem_addr, 32'hA);
    rst = 1'b1;
    bus.jump_en = 1'b1;
    tick();
    #1 chk_reset_outputs();
    tick();
    bus.jump_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("rel_addr", bus.mem_addr, RST_PC);
    bus.id_ready = 1'b0;
    wait_valid(12, n);
    chk("rel_pc", bus.pc_out, RST_PC);
    chk("rel_inst", bus.inst_out, mem_word(RST_PC));
    bus.id_ready = 1'b1;
    tick();

    // Randomized traffic checked by the stream model inside tick().
    ntransfer = 0;
    repeat (400) begin
      bus.mem_gnt     = ($urandom_range(0, 3) != 0);
      bus.id_ready    = ($urandom_range(0, 1) != 0);
      bus.jump_en     = ($urandom_range(0, 24) == 0);
      bus.jump_target = $urandom;
      rst             = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus.jump_en = 1'b0;
    bus.mem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    repeat (12) tick();
    chk("rand_progress", {31'd0, ntransfer > 10}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
